delay_line_tank: RTL and testbench

- Behavioural model of one EDSAC mercury delay-line tank: the memory-side responder to the control-section tank decoders.
- Responds to the per-tank in/out/clr gates and the serial mib data.
- Recirculates its contents bit-serially, one digit time per clock, and returns the serial mob stream.
- Instantiated once per tank; 4 tanks up and 4 down per rack, in racks f1/f2/r1/r2, inside the memory unit.

---
 rtl/edsac_pkg.sv | 29 ++
 rtl/minor_cycle_counter.sv | 57 +++++
 rtl/delay_line_tank.sv | 71 +++++++
 tb/tb_delay_line_tank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_pkg.sv
// Shared EDSAC store constants and types used by the tank model and its
// minor-cycle timing counter.
package edsac_pkg;

  localparam int EDSAC_DIGITS          = 36;
  localparam int EDSAC_TANK_WORDS_LONG = 16;

  typedef logic [5:0] digit_idx_t;

  // Source of the bit entering the tail of the line on each digit time.
  typedef enum logic [1:0] {
    TAIL_RECIRC = 2'd0,
    TAIL_CLEAR  = 2'd1,
    TAIL_WRITE  = 2'd2
  } tail_sel_e;

  // Write beats clear; clear only suppresses recirculation.
  function automatic tail_sel_e tail_select(input logic wr, input logic clr);
    tail_sel_e sel;
    sel = TAIL_RECIRC;
    if (wr) begin
      sel = TAIL_WRITE;
    end else if (clr) begin
      sel = TAIL_CLEAR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/minor_cycle_counter.sv
// Digit/word position counters for one tank, realigned by the d0 digit
// pulse, with a sticky flag recording any out-of-phase d0.
module minor_cycle_counter
  import edsac_pkg::*;
#(
  parameter int WORDS  = EDSAC_TANK_WORDS_LONG,
  parameter int DIGITS = EDSAC_DIGITS,
  parameter int PW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d0,
  output logic [PW-1:0] word_pos,
  output digit_idx_t    digit_pos,
  output logic          sync_err
);

  localparam digit_idx_t    LAST_DIGIT = digit_idx_t'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_WORD  = PW'(WORDS - 1);

  digit_idx_t    digit_reg, digit_next;
  logic [PW-1:0] word_reg, word_next;
  logic          err_reg, err_next;

  always_comb begin
    digit_next = digit_reg;
    word_next  = word_reg;
    err_next   = err_reg;
    if (d0 && (digit_reg != LAST_DIGIT)) begin
      // Out-of-phase d0: snap to digit 0 without disturbing the word count.
      digit_next = '0;
      err_next   = 1'b1;
    end else if (digit_reg == LAST_DIGIT) begin
      digit_next = '0;
      word_next  = (word_reg == LAST_WORD) ? '0 : word_reg + 1'b1;
    end else begin
      digit_next = digit_reg + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_reg <= '0;
      word_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      word_reg  <= word_next;
      err_reg   <= err_next;
    end
  end

  assign digit_pos = digit_reg;
  assign word_pos  = word_reg;
  assign sync_err  = err_reg;

endmodule

// File: rtl/delay_line_tank.sv
// One mercury delay-line tank: a WORDS*DIGITS bit recirculating line with
// write/clear/read gating and the minor-cycle position counters.
module delay_line_tank
  import edsac_pkg::*;
#(
  parameter int WORDS  = EDSAC_TANK_WORDS_LONG,
  parameter int DIGITS = EDSAC_DIGITS,
  parameter int PW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d0,
  input  logic          tank_in,
  input  logic          tank_clr,
  input  logic          tank_out,
  input  logic          mib,
  output logic          mob,
  output logic [PW-1:0] word_pos,
  output digit_idx_t    digit_pos,
  output logic          sync_err
);

  localparam int LEN = WORDS * DIGITS;

  logic [LEN-1:0] line_reg;
  logic [LEN-1:0] line_next;
  logic           tail_next;

  // mib only reaches the line through the write gate, so a floating bus
  // cannot leak into stored words.
  always_comb begin
    tail_next = line_reg[0];
    case (tail_select(tank_in, tank_clr))
      TAIL_WRITE:  tail_next = mib;
      TAIL_CLEAR:  tail_next = 1'b0;
      default:     tail_next = line_reg[0];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LEN - 1; gi++) begin : g_shift
      assign line_next[gi] = line_reg[gi + 1];
    end
  endgenerate
  assign line_next[LEN-1] = tail_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_reg <= '0;
    end else begin
      line_reg <= line_next;
    end
  end

  assign mob = tank_out & line_reg[0];

  minor_cycle_counter #(
    .WORDS  (WORDS),
    .DIGITS (DIGITS),
    .PW     (PW)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .word_pos  (word_pos),
    .digit_pos (digit_pos),
    .sync_err  (sync_err)
  );

endmodule

// File: tb/tb_delay_line_tank.sv
// Scoreboard bench for delay_line_tank: the driver models the tank as an
// addressable word/digit store and queues expected outputs per digit time.
module tb_delay_line_tank;

  localparam int WORDS  = 16;
  localparam int DIGITS = 36;
  localparam int PW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d0 = 1'b0;
  logic          tank_in = 1'b0;
  logic          tank_clr = 1'b0;
  logic          tank_out = 1'b0;
  logic          mib = 1'b0;
  logic          mob;
  logic [PW-1:0] word_pos;
  logic [5:0]    digit_pos;
  logic          sync_err;

  always #5 clk = ~clk;

  delay_line_tank #(
    .WORDS  (WORDS),
    .DIGITS (DIGITS),
    .PW     (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .tank_in   (tank_in),
    .tank_clr  (tank_clr),
    .tank_out  (tank_out),
    .mib       (mib),
    .mob       (mob),
    .word_pos  (word_pos),
    .digit_pos (digit_pos),
    .sync_err  (sync_err)
  );

  typedef struct {
    logic       mob;
    bit         mob_chk;
    logic [3:0] w;
    logic [5:0] d;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int vectors    = 0;
  int miscompares = 0;
  int pushed     = 0;
  int popped     = 0;

  // Reference: the tank as mem[word][digit], addressed by the nominal position.
  bit mem[WORDS][DIGITS];
  int mw = 0;
  int mp = 0;
  bit merr = 1'b0;
  bit mob_known = 1'b1;

  function automatic void model_clear();
    for (int w = 0; w < WORDS; w++)
      for (int p = 0; p < DIGITS; p++)
        mem[w][p] = 1'b0;
    mw = 0;
    mp = 0;
    merr = 1'b0;
    mob_known = 1'b1;
  endfunction

  // One digit time: drive, queue the expectation for this cycle, advance model.
  task automatic step(input bit in_v, input bit clr_v, input bit out_v,
                      input bit mib_v, input bit d0_v);
    exp_t e;
    tank_in  = in_v;
    tank_clr = clr_v;
    tank_out = out_v;
    mib      = mib_v;
    d0       = d0_v;
    e.mob     = out_v & mem[mw][mp];
    e.mob_chk = mob_known;
    e.w       = mw[3:0];
    e.d       = mp[5:0];
    e.err     = merr;
    sb_q.push_back(e);
    pushed++;
    if (in_v) mem[mw][mp] = mib_v;
    else if (clr_v) mem[mw][mp] = 1'b0;
    if (d0_v && mp != DIGITS - 1) begin
      mp = 0;
      merr = 1'b1;
      mob_known = 1'b0;
    end else if (mp == DIGITS - 1) begin
      mp = 0;
      mw = (mw + 1) % WORDS;
    end else begin
      mp = mp + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), mp == DIGITS - 1);
  endtask

  task automatic goto_word(input int w);
    while (!(mw == w && mp == 0)) idle(1);
  endtask

  task automatic write_word(input int w, input logic [35:0] v, input bit out_v);
    logic [35:0] val;
    val = v;
    goto_word(w);
    for (int p = 0; p < DIGITS; p++)
      step(1'b1, 1'b0, out_v, val[p], mp == DIGITS - 1);
  endtask

  task automatic clear_word(input int w);
    goto_word(w);
    for (int p = 0; p < DIGITS; p++)
      step(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), mp == DIGITS - 1);
  endtask

  task automatic read_rev();
    for (int i = 0; i < WORDS * DIGITS; i++)
      step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), mp == DIGITS - 1);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (mob !== 1'b0 || word_pos !== '0 || digit_pos !== '0 || sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got mob=%b word=%0d digit=%0d err=%b, want all 0",
               tag, mob, word_pos, digit_pos, sync_err);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for clk.
  task automatic mid_reset();
    tank_out = 1'b1;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      popped++;
      vectors++;
      if ((mon_e.mob_chk && mob !== mon_e.mob) || word_pos !== mon_e.w ||
          digit_pos !== mon_e.d || sync_err !== mon_e.err) begin
        miscompares++;
        $display("FAIL cycle %0d: got mob=%b word=%0d digit=%0d err=%b, want mob=%b(chk=%0b) word=%0d digit=%0d err=%b",
                 popped, mob, word_pos, digit_pos, sync_err,
                 mon_e.mob, mon_e.mob_chk, mon_e.w, mon_e.d, mon_e.err);
      end
    end
  end

  initial begin
    model_clear();
    tank_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("power_on_reset");
    rst = 1'b0;
    $display("reset released");

    for (int i = 0; i < WORDS * DIGITS; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, mp == DIGITS - 1);
    idle(50);
    mid_reset();
    read_rev();
    $display("mid-run reset then full read of zeros");

    write_word(0, 36'hF_0000_0001, 1'b0);
    write_word(3, 36'h9_5555_AAAA, 1'b0);
    write_word(4, 36'h1_2345_6789, 1'b0);
    write_word(5, 36'h3_FFFF_FFFF, 1'b0);
    write_word(6, 36'h8_7654_3210, 1'b0);
    write_word(7, 36'hA_AAAA_AAAA, 1'b0);
    read_rev();
    $display("words written and read back");

    idle(10 * WORDS * DIGITS);
    read_rev();
    $display("ten revolutions recirculated");

    clear_word(5);
    read_rev();
    $display("word 5 cleared");

    write_word(7, 36'h0, 1'b1);
    read_rev();
    $display("word 7 read-modify-write");

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), mp == DIGITS - 1);
    read_rev();
    $display("random gating traffic");

    while (mp != 17) idle(1);
    step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    idle(300);
    $display("out-of-phase d0 realign");

    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (pushed != popped || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got popped=%0d, want %0d", popped, pushed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
